// File: rtl/trigger_seq_pkg.sv
// Shared types and helpers for the trigger sequence generator.
package trigger_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StTail = 2'd2
    } seq_state_e;

    // Bits needed to index 2..16 trigger slots.
    function automatic int unsigned slot_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end else if (n <= 4) begin
            return 2;
        end else if (n <= 8) begin
            return 3;
        end
        return 4;
    endfunction

    function automatic logic [31:0] clamp_min1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic logic [31:0] clamp_max(input logic [31:0] v, input logic [31:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/trigger_edge_detect.sv
// Two-flop registration of an input with a registered rising-edge pulse.
module trigger_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic r1_q, r2_q, pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            r1_q    <= sig_i;
            r2_q    <= r1_q;
            pulse_q <= r1_q & ~r2_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/trigger_sequence_generator.sv
// Programmed multi-slot trigger pulse generator in the adc_clk domain.
// Optional TRIG_SEQ_GEN_REPEAT_EN adds repeated runs separated by a programmable gap.
module trigger_sequence_generator
    import trigger_seq_pkg::*;
#(
    parameter int unsigned pNUM_TRIGGERS  = 4,
    parameter int unsigned pCOUNTER_WIDTH = 16,
    parameter int unsigned pPW_WIDTH      = 8
) (
    input  logic                                        adc_clk,
    input  logic                                        reset,
    input  logic                                        I_enable,
    input  logic                                        I_start,
    input  logic [(pNUM_TRIGGERS-1)*pCOUNTER_WIDTH-1:0] I_delay,
    input  logic [pPW_WIDTH-1:0]                        I_pulse_width,
    input  logic [3:0]                                  I_last_trigger,
    input  logic                                        I_clear_status,
`ifdef TRIG_SEQ_GEN_REPEAT_EN
    input  logic [7:0]                                  I_repeat,
    input  logic [pCOUNTER_WIDTH-1:0]                   I_repeat_gap,
`endif
    output logic [pNUM_TRIGGERS-1:0]                    O_trigger,
    output logic                                        O_busy,
    output logic                                        O_done,
    output logic                                        O_overrun
);

    localparam int unsigned NT   = pNUM_TRIGGERS;
    localparam int unsigned SW   = slot_width(pNUM_TRIGGERS);
    // Wide enough for both delay counts and the pulse-width count up to pw_eff.
    localparam int unsigned CntW = (pCOUNTER_WIDTH > pPW_WIDTH) ? pCOUNTER_WIDTH : pPW_WIDTH + 1;
    localparam logic [NT-1:0] OneHot0 = NT'(1);

    seq_state_e      state_q;
    logic [SW-1:0]   slot_q, last_q;
    logic [CntW-1:0] cnt_q, pw_q;
    logic [CntW-1:0] d_q [NT];
    logic [NT-1:0]   trig_q;
    logic            busy_q, done_q, overrun_q, start_q;

    logic            start_edge;
    logic [CntW-1:0] cnt_inc, d_cur, tail_lim;
    logic [SW-1:0]   slot_inc, last_eff;
    logic            repeat_pending;

    trigger_edge_detect u_start_edge (
        .clk_i   (adc_clk),
        .rst_i   (reset),
        .sig_i   (I_start),
        .pulse_o (start_edge)
    );

    assign cnt_inc  = cnt_q + CntW'(1);
    assign d_cur    = d_q[slot_q];
    assign slot_inc = slot_q + SW'(1);
    assign last_eff = SW'(clamp_max(32'(I_last_trigger), 32'(NT - 1)));

`ifdef TRIG_SEQ_GEN_REPEAT_EN
    logic [7:0]      runs_q;
    logic [CntW-1:0] gap_q;
    assign repeat_pending = (runs_q != 8'd0);
    assign tail_lim       = repeat_pending ? gap_q : pw_q;
`else
    assign repeat_pending = 1'b0;
    assign tail_lim       = pw_q;
`endif

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            pw_q      <= CntW'(1);
            trig_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
            for (int i = 0; i < int'(NT); i++) begin
                d_q[i] <= CntW'(1);
            end
`ifdef TRIG_SEQ_GEN_REPEAT_EN
            runs_q    <= 8'd0;
            gap_q     <= CntW'(1);
`endif
        end else begin
            start_q <= start_edge;
            done_q  <= 1'b0;

            if (I_clear_status) begin
                overrun_q <= 1'b0;
            end else if (start_q && state_q != StIdle) begin
                overrun_q <= 1'b1;
            end

            if (state_q != StIdle && !I_enable) begin
                state_q <= StIdle;
                trig_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_q && I_enable) begin
                            pw_q <= CntW'(clamp_min1(32'(I_pulse_width)));
                            for (int i = 0; i < int'(NT) - 1; i++) begin
                                d_q[i] <= CntW'(clamp_min1(
                                    32'(I_delay[i*pCOUNTER_WIDTH +: pCOUNTER_WIDTH])));
                            end
                            d_q[NT-1] <= CntW'(1);
                            last_q    <= last_eff;
                            slot_q    <= '0;
                            cnt_q     <= '0;
                            trig_q    <= OneHot0;
                            busy_q    <= 1'b1;
                            state_q   <= (last_eff == '0) ? StTail : StRun;
`ifdef TRIG_SEQ_GEN_REPEAT_EN
                            runs_q    <= I_repeat;
                            gap_q     <= CntW'(clamp_min1(32'(I_repeat_gap)));
`endif
                        end
                    end
                    StRun: begin
                        if (cnt_q == d_cur - CntW'(1)) begin
                            slot_q  <= slot_inc;
                            cnt_q   <= '0;
                            trig_q  <= OneHot0 << slot_inc;
                            state_q <= (slot_inc == last_q) ? StTail : StRun;
                        end else begin
                            cnt_q  <= cnt_inc;
                            trig_q <= (cnt_inc < pw_q && cnt_inc < d_cur) ?
                                      (OneHot0 << slot_q) : '0;
                        end
                    end
                    StTail: begin
                        if (repeat_pending && cnt_q == tail_lim - CntW'(1)) begin
                            slot_q  <= '0;
                            cnt_q   <= '0;
                            trig_q  <= OneHot0;
                            state_q <= (last_q == '0) ? StTail : StRun;
`ifdef TRIG_SEQ_GEN_REPEAT_EN
                            runs_q  <= runs_q - 8'd1;
`endif
                        end else if (!repeat_pending && cnt_q == pw_q) begin
                            // O_done was high this cycle; busy drops with it.
                            state_q <= StIdle;
                            trig_q  <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_inc;
                            trig_q <= (cnt_inc < pw_q && cnt_inc < tail_lim) ?
                                      (OneHot0 << slot_q) : '0;
                            done_q <= !repeat_pending && (cnt_inc == pw_q);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        trig_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O_trigger = trig_q;
    assign O_busy    = busy_q;
    assign O_done    = done_q;
    assign O_overrun = overrun_q;

endmodule
